card_pile_controller: RTL



---
 rtl/card_pile_controller.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/card_pile_controller.sv
// card_pile_controller: three 52-slot card piles (deck, player, com) with
// APPEND / REMOVE / INIT / COUNT operations driven by a small FSM.
//
// Handshake: in IDLE a high 'enable' at a rising edge captures select_op,
// arg1 and arg2 and starts one operation; busy stays high until the
// controller is back in IDLE. Completion is a single-cycle finished_op
// pulse (the DONE state); error and out1 are valid in that cycle and hold
// until the next completion. enable is ignored whenever busy is high.
//
// Non-INIT operations spend two cycles in EXEC: the first resolves the pile
// count and REMOVE index into registers, and the second acts on them. That
// keeps the count compare off the slot read/write path.
module card_pile_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  select_op,
    input  logic [1:0]  arg1,
    input  logic [5:0]  arg2,
    output logic        finished_op,
    output logic [15:0] out1,
    output logic        error,
    output logic        busy,
    output logic [5:0]  deck_count,
    output logic [5:0]  player_count,
    output logic [5:0]  com_count
);

    localparam logic [1:0] OP_APPEND = 2'd0;
    localparam logic [1:0] OP_REMOVE = 2'd1;
    localparam logic [1:0] OP_INIT   = 2'd2;
    localparam logic [1:0] OP_COUNT  = 2'd3;

    localparam logic [1:0] PILE_BAD  = 2'd3;
    localparam logic [5:0] PILE_MAX  = 6'd52;
    localparam logic [5:0] LAST_SLOT = 6'd51;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_SHIFT = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Captured request.
    logic [1:0]  r_op;
    logic [1:0]  r_pile;
    logic [5:0]  r_arg;
    logic        r_phase;      // 0 = first EXEC cycle, 1 = second

    // r_idx: REMOVE index, then shift pointer; INIT fill address.
    logic [5:0]  r_idx;
    logic [1:0]  r_suit;
    logic [3:0]  r_rank;

    logic [15:0] r_out1;
    logic        r_error;
    logic [5:0]  r_count [0:2];
    logic [5:0]  r_slot  [0:2][0:51];

    // Decoded view of the selected pile.
    logic        w_pile_valid;
    logic [1:0]  w_pile_ix;
    logic [5:0]  w_cnt;
    logic        w_full;
    logic        w_empty;
    logic [5:0]  w_top;
    logic        w_pos_ok;
    logic [5:0]  w_idx;
    logic [5:0]  w_rd_card;
    logic [5:0]  w_next_card;
    logic        w_shift_last;
    logic        w_remove_shift;

    // Slot write port.
    logic        w_wr_en;
    logic [1:0]  w_wr_pile;
    logic [5:0]  w_wr_addr;
    logic [5:0]  w_wr_data;

    // Selected-pile decode, REMOVE index resolution and shift bookkeeping.
    always_comb begin
        w_pile_valid   = (r_pile != PILE_BAD);
        w_pile_ix      = w_pile_valid ? r_pile : 2'd0;
        w_cnt          = r_count[w_pile_ix];
        w_full         = (w_cnt == PILE_MAX);
        w_empty        = (w_cnt == 6'd0);
        w_top          = w_empty ? 6'd0 : (w_cnt - 6'd1);
        w_pos_ok       = (r_arg != 6'd0) && (r_arg <= w_cnt);
        w_idx          = w_pos_ok ? (r_arg - 6'd1) : w_top;
        w_rd_card      = r_slot[w_pile_ix][r_idx];
        w_next_card    = r_slot[w_pile_ix][r_idx + 6'd1];
        // The copy done at pointer count-2 is the last one.
        w_shift_last   = (({1'b0, r_idx} + 7'd2) >= {1'b0, w_cnt});
        w_remove_shift = w_pile_valid && (r_op == OP_REMOVE) && !w_empty
                         && (r_idx != w_top);
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (!r_phase) begin
                    if (r_op == OP_INIT) w_next_state = S_FILL;
                end else if (w_remove_shift) begin
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) w_next_state = S_DONE;
            end
            S_FILL: begin
                if (r_idx == LAST_SLOT) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Slot write port: APPEND store, REMOVE shift-down copy, INIT deck fill.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_pile = 2'd0;
        w_wr_addr = 6'd0;
        w_wr_data = 6'd0;
        case (r_state)
            S_EXEC: begin
                if (r_phase && w_pile_valid && (r_op == OP_APPEND) && !w_full) begin
                    w_wr_en   = 1'b1;
                    w_wr_pile = w_pile_ix;
                    w_wr_addr = w_cnt;
                    w_wr_data = r_arg;
                end
            end
            S_SHIFT: begin
                w_wr_en   = 1'b1;
                w_wr_pile = w_pile_ix;
                w_wr_addr = r_idx;
                w_wr_data = w_next_card;
            end
            S_FILL: begin
                w_wr_en   = 1'b1;
                w_wr_pile = 2'd0;
                w_wr_addr = r_idx;
                w_wr_data = {r_suit, r_rank};
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    // State register; reset wins over any request in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Slot storage; no reset needed because every count clears to 0.
    always_ff @(posedge clock) begin
        if (w_wr_en) r_slot[w_wr_pile][w_wr_addr] <= w_wr_data;
    end

    // Request capture, counts, results and fill counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op     <= OP_APPEND;
            r_pile   <= 2'd0;
            r_arg    <= 6'd0;
            r_phase  <= 1'b0;
            r_idx    <= 6'd0;
            r_suit   <= 2'd0;
            r_rank   <= 4'd1;
            r_out1   <= 16'd0;
            r_error  <= 1'b0;
            for (int i = 0; i < 3; i++) r_count[i] <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_op    <= select_op;
                        r_pile  <= arg1;
                        r_arg   <= arg2;
                        r_phase <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        if (r_op == OP_INIT) begin
                            r_count[1] <= 6'd0;
                            r_count[2] <= 6'd0;
                            r_idx      <= 6'd0;
                            r_suit     <= 2'd0;
                            r_rank     <= 4'd1;
                        end else begin
                            r_idx <= w_idx;
                        end
                    end else if (!w_pile_valid) begin
                        r_out1  <= 16'hFFFF;
                        r_error <= 1'b1;
                    end else begin
                        case (r_op)
                            OP_APPEND: begin
                                if (w_full) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_count[w_pile_ix] <= w_cnt + 6'd1;
                                    r_error            <= 1'b0;
                                end
                            end
                            OP_REMOVE: begin
                                if (w_empty) begin
                                    r_out1  <= 16'hFFFF;
                                    r_error <= 1'b1;
                                end else begin
                                    r_out1  <= {10'd0, w_rd_card};
                                    r_error <= 1'b0;
                                    // Removing the top card needs no shift.
                                    if (r_idx == w_top) r_count[w_pile_ix] <= w_top;
                                end
                            end
                            OP_COUNT: begin
                                r_out1  <= {10'd0, w_cnt};
                                r_error <= 1'b0;
                            end
                            default: begin
                                r_error <= r_error;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    r_idx <= r_idx + 6'd1;
                    if (w_shift_last) r_count[w_pile_ix] <= w_top;
                end
                S_FILL: begin
                    r_idx <= r_idx + 6'd1;
                    if (r_rank == 4'd13) begin
                        r_rank <= 4'd1;
                        r_suit <= r_suit + 2'd1;
                    end else begin
                        r_rank <= r_rank + 4'd1;
                    end
                    if (r_idx == LAST_SLOT) begin
                        r_count[0] <= PILE_MAX;
                        r_out1     <= {10'd0, PILE_MAX};
                        r_error    <= 1'b0;
                    end
                end
                default: begin
                    r_phase <= r_phase;
                end
            endcase
        end
    end

    assign finished_op  = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign out1         = r_out1;
    assign error        = r_error;
    assign deck_count   = r_count[0];
    assign player_count = r_count[1];
    assign com_count    = r_count[2];

endmodule
